frame_controller: RTL and testbench

Sequences one frame through the detection pipeline and then reads the resulting object table. It paces pixel ingestion from a source with a valid/ready handshake, drives the pipeline enable and pixel co-ordinates, and flushes the pipeline after the last pixel. It then sweeps `obj_id` across the object data table, emitting one report per populated entry on a valid/ready output. It sits between the frame source/sink and `top`, replacing free-running `location_generator` pacing.

---
 rtl/frame_controller.sv | 152 +++++++++++++++
 tb/tb_frame_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/frame_controller.sv
// frame_controller: paces one frame of pixels into the detection pipeline, drains it,
// then sweeps the object table and emits one report per populated entry.
module frame_controller #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int PIPE_DEPTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int MAX_OBJ      = 255,
    parameter int WORD_SIZE    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    output logic                 pipe_en_o,
    output logic [15:0]          x_o,
    output logic [15:0]          y_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic [WORD_SIZE-1:0] obj_id_o,
    input  logic [15:0]          obj_x_i,
    input  logic [15:0]          obj_y_i,
    output logic                 rpt_valid_o,
    input  logic                 rpt_ready_i,
    output logic [WORD_SIZE-1:0] rpt_id_o,
    output logic [15:0]          rpt_x_o,
    output logic [15:0]          rpt_y_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int FW = PIPE_DEPTH > 1 ? $clog2(PIPE_DEPTH) : 1;
    localparam int LW = READ_LATENCY > 0 ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_FLUSH  = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [FW-1:0]        fl_q, fl_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [WORD_SIZE-1:0] obj_id_q, obj_id_d, rpt_id_q, rpt_id_d;
    logic [15:0]          rpt_x_q, rpt_x_d, rpt_y_q, rpt_y_d;
    logic                 accept, x_last, y_last, sampled, advance;

    assign accept  = state_q == S_SCAN && src_valid_i;
    assign x_last  = x_q == XW'(WIDTH - 1);
    assign y_last  = y_q == YW'(HEIGHT - 1);
    assign sampled = state_q == S_READ && lat_q == LW'(READ_LATENCY);
    // An entry resolves either by being empty at sample time or by its report handshaking
    assign advance = (sampled && obj_x_i == '0 && obj_y_i == '0) ||
                     (state_q == S_REPORT && rpt_ready_i);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        fl_d     = fl_q;
        lat_d    = lat_q;
        obj_id_d = obj_id_q;
        rpt_id_d = rpt_id_q;
        rpt_x_d  = rpt_x_q;
        rpt_y_d  = rpt_y_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_SCAN;
                x_d     = '0;
                y_d     = '0;
            end
            S_SCAN: if (accept) begin
                x_d = x_last ? '0 : x_q + XW'(1);
                y_d = x_last ? (y_last ? '0 : y_q + YW'(1)) : y_q;
                if (x_last && y_last) begin
                    state_d = S_FLUSH;
                    fl_d    = '0;
                end
            end
            S_FLUSH: begin
                fl_d = fl_q + FW'(1);
                if (fl_q == FW'(PIPE_DEPTH - 1)) begin
                    state_d  = S_READ;
                    obj_id_d = WORD_SIZE'(1);
                    lat_d    = '0;
                end
            end
            S_READ: begin
                lat_d = sampled ? lat_q : lat_q + LW'(1);
                if (sampled && !advance) begin
                    state_d  = S_REPORT;
                    rpt_id_d = obj_id_q;
                    rpt_x_d  = obj_x_i;
                    rpt_y_d  = obj_y_i;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                obj_id_d = '0;
            end
            default: ;
        endcase
        if (advance) begin
            state_d  = obj_id_q == WORD_SIZE'(MAX_OBJ) ? S_DONE : S_READ;
            obj_id_d = obj_id_q == WORD_SIZE'(MAX_OBJ) ? obj_id_q : obj_id_q + WORD_SIZE'(1);
            lat_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            fl_q     <= '0;
            lat_q    <= '0;
            obj_id_q <= '0;
            rpt_id_q <= '0;
            rpt_x_q  <= '0;
            rpt_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fl_q     <= fl_d;
            lat_q    <= lat_d;
            obj_id_q <= obj_id_d;
            rpt_id_q <= rpt_id_d;
            rpt_x_q  <= rpt_x_d;
            rpt_y_q  <= rpt_y_d;
        end
    end

    assign src_ready_o = state_q == S_SCAN;
    assign pipe_en_o   = accept || state_q == S_FLUSH;
    assign x_o         = 16'(x_q);
    assign y_o         = 16'(y_q);
    assign hsync_o     = accept && x_q == '0;
    assign vsync_o     = hsync_o && y_q == '0;
    assign obj_id_o    = obj_id_q;
    assign rpt_valid_o = state_q == S_REPORT;
    assign rpt_id_o    = rpt_id_q;
    assign rpt_x_o     = rpt_x_q;
    assign rpt_y_o     = rpt_y_q;
    assign busy_o      = state_q != S_IDLE;
    assign done_o      = state_q == S_DONE;
endmodule

// File: tb/tb_frame_controller.sv
// tb_frame_controller: randomized frames and table sweeps checked against a raster/table reference model.
module tb_frame_controller;
    localparam int W = 4, H = 2, PD = 3, RL = 2, MAXO = 5, WS = 8;

    logic          clk_i = 0, reset_n_i, start_i, src_valid_i, rpt_ready_i;
    logic          src_ready_o, pipe_en_o, hsync_o, vsync_o, rpt_valid_o, busy_o, done_o;
    logic [15:0]   x_o, y_o, obj_x_i, obj_y_i, rpt_x_o, rpt_y_o;
    logic [WS-1:0] obj_id_o, rpt_id_o;
    logic [15:0]   tx [256], ty [256], s1x, s1y, s2x, s2y;
    int            n_assert = 0, n_fail = 0;

    frame_controller #(.WIDTH(W), .HEIGHT(H), .PIPE_DEPTH(PD), .READ_LATENCY(RL),
                       .MAX_OBJ(MAXO), .WORD_SIZE(WS)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .src_valid_i(src_valid_i),
        .src_ready_o(src_ready_o), .pipe_en_o(pipe_en_o), .x_o(x_o), .y_o(y_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .obj_id_o(obj_id_o), .obj_x_i(obj_x_i),
        .obj_y_i(obj_y_i), .rpt_valid_o(rpt_valid_o), .rpt_ready_i(rpt_ready_i),
        .rpt_id_o(rpt_id_o), .rpt_x_o(rpt_x_o), .rpt_y_o(rpt_y_o), .busy_o(busy_o), .done_o(done_o));

    always #5 clk_i = ~clk_i;

    // Object table behind a fixed RL-cycle read pipeline
    always @(posedge clk_i) begin
        s1x <= tx[obj_id_o];
        s1y <= ty[obj_id_o];
        s2x <= s1x;
        s2y <= s1y;
    end
    assign obj_x_i = s2x;
    assign obj_y_i = s2y;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n_i = 0;
        #1;
        chk(tag, 32'(|{src_ready_o, pipe_en_o, x_o, y_o, hsync_o, vsync_o, obj_id_o, rpt_valid_o,
                       rpt_id_o, rpt_x_o, rpt_y_o, busy_o, done_o}), 0);
        start_i = 0;
        src_valid_i = 0;
        @(negedge clk_i);
        reset_n_i = 1;
    endtask

    task automatic rand_table();
        for (int i = 1; i <= MAXO; i++) begin
            case ($urandom_range(2))
                0: begin tx[i] = 0; ty[i] = 0; end
                1: begin tx[i] = 16'($urandom_range(65535)); ty[i] = 16'($urandom_range(65535, 1)); end
                default: begin tx[i] = 16'($urandom_range(65535, 1)); ty[i] = 0; end
            endcase
        end
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; abort_acc>0 resets after that many accepts
    task automatic frame(input int vmode, input int min_stall, input bit noise,
                         input int abort_acc, input bit abort_rpt);
        int acc = 0, cyc = 0, st;
        @(negedge clk_i);
        start_i = 1;
        #1 chk("idle_busy", 32'(busy_o), 0);
        for (int py = 0; py < H; py++) for (int px = 0; px < W; px++) begin
            st = 0;
            do begin
                @(negedge clk_i);
                src_valid_i = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(cyc % 2) :
                              1'($urandom_range(2) != 0 || st >= 4);
                start_i = noise ? 1'($urandom_range(1)) : 1'b0;
                rpt_ready_i = 1'($urandom_range(1));
                #1;
                chk("scan_ready", 32'(src_ready_o), 1);
                chk("scan_busy", 32'(busy_o), 1);
                chk("scan_pipe_en", 32'(pipe_en_o), 32'(src_valid_i));
                chk("scan_x", 32'(x_o), px);
                chk("scan_y", 32'(y_o), py);
                chk("scan_hsync", 32'(hsync_o), 32'(src_valid_i && px == 0));
                chk("scan_vsync", 32'(vsync_o), 32'(src_valid_i && px == 0 && py == 0));
                cyc++;
                st++;
            end while (!src_valid_i);
            acc++;
            if (abort_acc > 0 && acc == abort_acc) begin
                @(negedge clk_i);
                do_reset("reset_scan_outs");
                return;
            end
        end
        for (int i = 0; i < PD; i++) begin
            @(negedge clk_i);
            src_valid_i = 1'($urandom_range(1));
            start_i = noise ? 1'($urandom_range(1)) : 1'b0;
            #1;
            chk("flush_ready", 32'(src_ready_o), 0);
            chk("flush_pipe_en", 32'(pipe_en_o), 1);
            chk("flush_xy", {x_o, y_o}, 0);
        end
        for (int id = 1; id <= MAXO; id++) begin
            for (int i = 0; i <= RL; i++) begin
                @(negedge clk_i);
                start_i = noise ? 1'($urandom_range(1)) : 1'b0;
                rpt_ready_i = 1'($urandom_range(1));
                #1;
                chk("read_obj_id", 32'(obj_id_o), id);
                chk("read_rpt_valid", 32'(rpt_valid_o), 0);
                chk("read_pipe_en", 32'(pipe_en_o), 0);
                chk("read_done", 32'(done_o), 0);
            end
            if (tx[id] != 0 || ty[id] != 0) begin
                st = 0;
                do begin
                    @(negedge clk_i);
                    rpt_ready_i = 1'(st >= min_stall && ($urandom_range(2) != 0 || st > min_stall + 5));
                    start_i = noise ? 1'($urandom_range(1)) : 1'b0;
                    #1;
                    chk("rpt_valid", 32'(rpt_valid_o), 1);
                    chk("rpt_id", 32'(rpt_id_o), id);
                    chk("rpt_x", 32'(rpt_x_o), 32'(tx[id]));
                    chk("rpt_y", 32'(rpt_y_o), 32'(ty[id]));
                    chk("rpt_obj_id", 32'(obj_id_o), id);
                    chk("rpt_pipe_en", 32'(pipe_en_o), 0);
                    if (abort_rpt && st == 1) begin
                        @(negedge clk_i);
                        do_reset("reset_rpt_outs");
                        return;
                    end
                    st++;
                end while (!rpt_ready_i);
            end
        end
        @(negedge clk_i);
        start_i = noise ? 1'($urandom_range(1)) : 1'b0;
        #1;
        chk("done_pulse", 32'(done_o), 1);
        chk("done_busy", 32'(busy_o), 1);
        chk("done_rpt_valid", 32'(rpt_valid_o), 0);
        @(negedge clk_i);
        start_i = 0;
        #1;
        chk("idle_done", 32'(done_o), 0);
        chk("idle_busy_after", 32'(busy_o), 0);
        chk("idle_obj_id", 32'(obj_id_o), 0);
        @(negedge clk_i);
        #1 chk("idle_stays", 32'(busy_o), 0);
    endtask

    initial begin
        reset_n_i = 0;
        start_i = 0;
        src_valid_i = 0;
        rpt_ready_i = 0;
        for (int i = 0; i < 256; i++) begin
            tx[i] = 0;
            ty[i] = 0;
        end
        repeat (2) @(negedge clk_i);
        chk("por_outs", 32'(|{src_ready_o, pipe_en_o, x_o, y_o, hsync_o, vsync_o, obj_id_o, rpt_valid_o,
                              rpt_id_o, rpt_x_o, rpt_y_o, busy_o, done_o}), 0);
        reset_n_i = 1;
        tx[2] = 10; ty[2] = 20;
        tx[3] = 5;  ty[3] = 7;
        ty[5] = 9;
        frame(0, 5, 0, 0, 0);
        frame(1, 0, 0, 0, 0);
        frame(0, 0, 0, 3, 0);
        frame(2, 0, 1, 0, 0);
        frame(2, 2, 0, 0, 1);
        frame(2, 1, 1, 0, 0);
        repeat (8) begin
            rand_table();
            frame(2, $urandom_range(3), 1, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
